// File: rtl/corr_run_seq_pkg.sv
// Shared definitions for the correlator run sequencer: state encodings,
// error codes and status-word bit positions.
package corr_run_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4,
        ST_CLEAR     = 3'd5,
        ST_ABORT     = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_FAIL  = 2'b01,
        ERR_TMO   = 2'b10,
        ERR_ABORT = 2'b11
    } err_code_t;

    localparam int SR_DONE_BIT = 0;
    localparam int SR_FAIL_BIT = 1;
    localparam int TMO_W       = 20;

endpackage

// File: rtl/corr_run_seq_if.sv
// Command/status bundle between a host, the run sequencer and the correlator.
// slave = sequencer side, master = host/correlator side.
interface corr_run_seq_if #(
    parameter int N_RUNS_W = 16
);
    logic [31:0]         sr;
    logic                cmd_start;
    logic                cmd_abort;
    logic [N_RUNS_W-1:0] n_runs;
    logic                corr_start;
    logic                corr_clr;
    logic                seq_busy;
    logic                seq_done;
    logic                seq_err;
    logic [1:0]          err_code;
    logic [N_RUNS_W-1:0] runs_done;

    modport master (
        output sr, cmd_start, cmd_abort, n_runs,
        input  corr_start, corr_clr, seq_busy, seq_done, seq_err, err_code, runs_done
    );

    modport slave (
        input  sr, cmd_start, cmd_abort, n_runs,
        output corr_start, corr_clr, seq_busy, seq_done, seq_err, err_code, runs_done
    );
endinterface

// File: rtl/corr_tmo_cnt.sv
// Wait-state timeout counter: clr reloads zero, en counts, expired flags the
// cycle on which the count would reach TMO_CYC.
module corr_tmo_cnt #(
    parameter int TMO_CYC = 1048575,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TMO_CYC);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Flagged one count early so the FSM leaves on the edge the count hits TMO_CYC.
    assign expired = en && (cnt_q >= LAST);

endmodule

// File: rtl/corr_run_seq.sv
// Correlator run sequencer: launches n_runs correlator runs back to back and
// reports completion, failure, timeout or abort. Optional retry: CORR_RETRY_EN.
module corr_run_seq
    import corr_run_seq_pkg::*;
#(
    parameter int N_RUNS_W  = 16,
    parameter int TMO_CYC   = 1048575,
    parameter int MAX_RETRY = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    corr_run_seq_if.slave bus
);

    seq_state_t          state_q, state_nxt;
    logic [N_RUNS_W-1:0] n_lat_q, n_lat_nxt;
    logic [N_RUNS_W-1:0] runs_q, runs_nxt;
    logic                start_q, start_nxt;
    logic                clr_q, clr_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                err_q, err_nxt;
    err_code_t           code_q, code_nxt;
    err_code_t           fault;
    logic                tmo_clr, tmo_en, tmo_exp;
    logic                sr_done, sr_fail;
    logic                unused_sr;

`ifdef CORR_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_q, retry_nxt;
    logic               rflag_q, rflag_nxt;
`else
    logic               unused_max_retry;
    assign unused_max_retry = ^MAX_RETRY;
`endif

    function automatic logic [N_RUNS_W-1:0] sat_inc(input logic [N_RUNS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The status word is already in the clk domain and is used as-is.
    assign sr_done   = bus.sr[SR_DONE_BIT];
    assign sr_fail   = bus.sr[SR_FAIL_BIT];
    assign unused_sr = ^bus.sr[31:2];

    corr_tmo_cnt #(
        .TMO_CYC (TMO_CYC),
        .CNT_W   (TMO_W)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    always_comb begin
        state_nxt = state_q;
        n_lat_nxt = n_lat_q;
        runs_nxt  = runs_q;
        start_nxt = 1'b0;
        clr_nxt   = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = err_q;
        code_nxt  = code_q;
        fault     = ERR_NONE;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
`ifdef CORR_RETRY_EN
        retry_nxt = retry_q;
        rflag_nxt = rflag_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_start) begin
                    n_lat_nxt = bus.n_runs;
                    runs_nxt  = '0;
                    err_nxt   = 1'b0;
                    code_nxt  = ERR_NONE;
`ifdef CORR_RETRY_EN
                    retry_nxt = '0;
                    rflag_nxt = 1'b0;
`endif
                    if (bus.n_runs == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                start_nxt = 1'b1;
                tmo_clr   = 1'b1;
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                tmo_en = 1'b1;
                if (!sr_done) begin
                    tmo_clr   = 1'b1;
                    state_nxt = ST_WAIT_DONE;
                end else if (tmo_exp) begin
                    code_nxt  = ERR_TMO;
                    state_nxt = ST_CLEAR;
                end
            end
            ST_WAIT_DONE: begin
                tmo_en = 1'b1;
                // Failure outranks done when both rise together.
                if (sr_fail || (!sr_done && tmo_exp)) begin
                    fault     = sr_fail ? ERR_FAIL : ERR_TMO;
                    state_nxt = ST_CLEAR;
`ifdef CORR_RETRY_EN
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_nxt = retry_q + 1'b1;
                        rflag_nxt = 1'b1;
                    end else begin
                        code_nxt = fault;
                    end
`else
                    code_nxt = fault;
`endif
                end else if (sr_done) begin
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                runs_nxt = sat_inc(runs_q);
`ifdef CORR_RETRY_EN
                retry_nxt = '0;
`endif
                if (runs_nxt == n_lat_q) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_CLEAR: begin
                clr_nxt = 1'b1;
`ifdef CORR_RETRY_EN
                if (rflag_q) begin
                    rflag_nxt = 1'b0;
                    state_nxt = ST_LAUNCH;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
`else
                err_nxt   = 1'b1;
                state_nxt = ST_IDLE;
`endif
            end
            ST_ABORT: begin
                clr_nxt   = 1'b1;
                err_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the current state would have done.
        if (bus.cmd_abort && (state_q != ST_IDLE) && (state_q != ST_ABORT)) begin
            state_nxt = ST_ABORT;
            code_nxt  = ERR_ABORT;
            runs_nxt  = runs_q;
            start_nxt = 1'b0;
            clr_nxt   = 1'b0;
            done_nxt  = 1'b0;
            err_nxt   = err_q;
`ifdef CORR_RETRY_EN
            rflag_nxt = 1'b0;
`endif
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            runs_q  <= '0;
            start_q <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
`ifdef CORR_RETRY_EN
            retry_q <= '0;
            rflag_q <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            runs_q  <= runs_nxt;
            start_q <= start_nxt;
            clr_q   <= clr_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            code_q  <= code_nxt;
`ifdef CORR_RETRY_EN
            retry_q <= retry_nxt;
            rflag_q <= rflag_nxt;
`endif
        end
    end

    // Latched run count is only consulted after a start has loaded it.
    always_ff @(posedge clk) begin
        n_lat_q <= n_lat_nxt;
    end

    assign bus.corr_start = start_q;
    assign bus.corr_clr   = clr_q;
    assign bus.seq_busy   = busy_q;
    assign bus.seq_done   = done_q;
    assign bus.seq_err    = err_q;
    assign bus.err_code   = code_q;
    assign bus.runs_done  = runs_q;

endmodule

// File: doc/corr_run_seq.md
CORR_RUN_SEQ -- requirements
Module: corr_run_seq

Interface
REQ-001 Parameter N_RUNS_W, default 16: width of the run-count input and counters.
REQ-002 Parameter TMO_CYC, default 1048575: maximum cycles allowed in any wait state; 20-bit timeout counter.
REQ-003 Parameter MAX_RETRY, default 3: retries per run when retry support is compiled in.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 sr  in  32  correlator status word: sr[0]=done, sr[1]=failure, other bits ignored; busy = ~sr[0].
REQ-007 cmd_start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
REQ-008 cmd_abort  in  1  level; forces ABORT from any non-IDLE state.
REQ-009 n_runs  in  N_RUNS_W  number of runs; latched on accepted cmd_start.
REQ-010 corr_start  out  1  one-cycle pulse that launches one correlator run.
REQ-011 corr_clr  out  1  one-cycle pulse that clears the correlator after abort or failure.
REQ-012 seq_busy  out  1  high in every state except IDLE.
REQ-013 seq_done  out  1  one-cycle pulse on successful sequence completion.
REQ-014 seq_err  out  1  sticky error flag; cleared by the next accepted cmd_start.
REQ-015 err_code  out  2  00 none, 01 correlator failure, 10 timeout, 11 abort.
REQ-016 runs_done  out  N_RUNS_W  count of completed runs in the current sequence.

Function
REQ-017 States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, NEXT, CLEAR, ABORT.
REQ-018 IDLE: cmd_start with n_runs!=0 -> LAUNCH, latch n_runs, runs_done<=0, seq_err<=0, err_code<=00.
REQ-019 IDLE: cmd_start with n_runs==0 -> seq_done pulses the next cycle and the block stays in IDLE.
REQ-020 LAUNCH: corr_start high for exactly one cycle -> WAIT_BUSY; timeout counter <=0.
REQ-021 WAIT_BUSY: sr[0]==0 -> WAIT_DONE, timeout counter <=0; counter reaching TMO_CYC -> CLEAR, err_code=10.
REQ-022 WAIT_DONE: sr[1]==1 -> CLEAR, err_code=01; sr[0]==1 with sr[1]==0 -> NEXT; timeout -> CLEAR, err_code=10.
REQ-023 Failure takes priority when sr[1] and sr[0] rise in the same cycle.
REQ-024 NEXT: runs_done increments; if the new value equals the latched n_runs, seq_done pulses -> IDLE, otherwise -> LAUNCH.
REQ-025 CLEAR: corr_clr pulses for one cycle, seq_err<=1 -> IDLE.
REQ-026 ABORT: entered on cmd_abort from any non-IDLE state, priority over all other transitions; corr_clr pulses, err_code=11, seq_err<=1 -> IDLE.
REQ-027 cmd_abort in IDLE has no effect; cmd_start outside IDLE is ignored.
REQ-028 sr is sampled directly, with no synchronizer, because it is in the clk domain.
REQ-029 runs_done saturates and never wraps; latency from cmd_start to corr_start is exactly 2 cycles.

Reset
REQ-030 Asserting rst_n low asynchronously forces IDLE and clears all counters.
REQ-031 On reset, corr_start, corr_clr, seq_busy, seq_done, seq_err, err_code and runs_done all go to 0.
REQ-032 Reset in mid-sequence emits no corr_clr pulse.
REQ-033 Outputs are registered, so no glitch reaches them on deassertion.

Configuration
REQ-034 Macro CORR_RETRY_EN compiles retry support in or out.
REQ-035 With CORR_RETRY_EN defined: a failure or timeout in WAIT_DONE with retry count < MAX_RETRY goes CLEAR -> LAUNCH for the same run, with no seq_err and no err_code change; the retry count resets in NEXT.
REQ-036 Without CORR_RETRY_EN: no retry counter exists and behaviour is exactly REQ-022/REQ-025.

Structure
REQ-037 State encodings and err_code values (ERR_NONE, ERR_FAIL, ERR_TMO, ERR_ABORT) live in the shared master-control package/header, together with the SR_DONE_BIT=0 and SR_FAIL_BIT=1 constants.
REQ-038 One sub-module, corr_tmo_cnt, holds the loadable timeout counter with clear, enable and expired flag.

Verification
REQ-039 n_runs=3, a model that drops sr[0] 2 cycles after corr_start and raises it 10 cycles later: 3 corr_start pulses, runs_done=3, a single seq_done pulse, err_code=00.
REQ-040 sr[1] rises in run 2 of 4 (retry off): corr_clr once, seq_err=1, err_code=01, runs_done=1.
REQ-041 TMO_CYC=16 with sr[0] held at 1: corr_clr at cycle 17 after entering WAIT_BUSY, err_code=10.
REQ-042 cmd_abort in WAIT_DONE of run 1: ABORT next cycle, corr_clr, err_code=11; a following cmd_start clears seq_err.
REQ-043 rst_n low while in WAIT_DONE: all outputs 0 immediately, with no corr_clr.
REQ-044 With CORR_RETRY_EN and MAX_RETRY=3, four consecutive failures: 3 retry launches, then seq_err=1 and err_code=01.
